pipe_addsub: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor for the processor datapath.
- Breaks the carry chain into CHUNK-bit slices, one slice per pipeline stage, so wide operands close timing at full clock rate.
- Produces sum/difference plus carry-out, signed overflow, not-equal and signed less-than flags.
- Valid/ready handshake on both sides; a pass-through tag lets the issuing stage match results to requests.

---
 rtl/pipe_addsub_if.sv | 56 +++++
 rtl/pipe_addsub.sv | 170 +++++++++++++++++
 tb/tb_pipe_addsub.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_addsub_if
//  Brief    : Request/response bundle for the pipelined adder/subtractor.
//             The sat request bit exists only when ADDSUB_SAT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_addsub_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    // Request side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             addsub;
    logic [TAG_W-1:0] in_tag;
`ifdef ADDSUB_SAT_EN
    logic             sat;
`endif

    // Response side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [TAG_W-1:0] out_tag;
    logic             cout;
    logic             overflow_out;
    logic             neq_out;
    logic             lt_out;

`ifdef ADDSUB_SAT_EN
    modport master (
        output in_valid, in1, in2, addsub, sat, in_tag, out_ready,
        input  in_ready, out_valid, out, out_tag, cout, overflow_out, neq_out, lt_out
    );

    modport slave (
        input  in_valid, in1, in2, addsub, sat, in_tag, out_ready,
        output in_ready, out_valid, out, out_tag, cout, overflow_out, neq_out, lt_out
    );
`else
    modport master (
        output in_valid, in1, in2, addsub, in_tag, out_ready,
        input  in_ready, out_valid, out, out_tag, cout, overflow_out, neq_out, lt_out
    );

    modport slave (
        input  in_valid, in1, in2, addsub, in_tag, out_ready,
        output in_ready, out_valid, out, out_tag, cout, overflow_out, neq_out, lt_out
    );
`endif

endinterface
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_addsub
//  Brief    : Pipelined two's-complement adder/subtractor, one CHUNK-bit carry
//             slice per stage, with carry/overflow/neq/lt flags and a tag.
//             Optional macro ADDSUB_SAT_EN adds per-operation saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 4
) (
    input  logic         clock,
    input  logic         reset,
    pipe_addsub_if.slave bus
);

    localparam int STAGES = WIDTH / CHUNK;

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic             w_adv;
    logic             r_out_vld;
    logic [WIDTH-1:0] r_out;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_cout;
    logic             r_ovf;
    logic             r_neq;
    logic             r_lt;

    // Whole pipeline moves or holds as one; no bubble collapsing.
    assign w_adv = !r_out_vld || bus.out_ready;

    assign bus.in_ready     = w_adv;
    assign bus.out_valid    = r_out_vld;
    assign bus.out          = r_out;
    assign bus.out_tag      = r_out_tag;
    assign bus.cout         = r_cout;
    assign bus.overflow_out = r_ovf;
    assign bus.neq_out      = r_neq;
    assign bus.lt_out       = r_lt;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // LO_W result bits are already finished when an op enters stage k;
        // HI_W operand bits (skew) are still waiting to be added.
        localparam int LO_W = k * CHUNK;
        localparam int HI_W = WIDTH - LO_W;

        logic                  w_vld;
        logic                  w_cin;
        logic [TAG_W-1:0]      w_tag;
        logic [HI_W-1:0]       w_a_hi;
        logic [HI_W-1:0]       w_bp_hi;
        logic [CHUNK:0]        w_sum;
        logic [LO_W+CHUNK-1:0] w_res;
`ifdef ADDSUB_SAT_EN
        logic                  w_sat;
`endif

        if (k == 0) begin : g_head
            // Subtract folds into an add of ~B with carry-in 1.
            assign w_vld   = bus.in_valid;
            assign w_tag   = bus.in_tag;
            assign w_a_hi  = bus.in1;
            assign w_bp_hi = bus.addsub ? ~bus.in2 : bus.in2;
            assign w_cin   = bus.addsub;
            assign w_res   = w_sum[CHUNK-1:0];
`ifdef ADDSUB_SAT_EN
            assign w_sat   = bus.sat;
`endif
        end else begin : g_tail
            assign w_vld   = g_stage[k-1].g_mid.r_vld;
            assign w_tag   = g_stage[k-1].g_mid.r_tag;
            assign w_a_hi  = g_stage[k-1].g_mid.r_a_hi;
            assign w_bp_hi = g_stage[k-1].g_mid.r_bp_hi;
            assign w_cin   = g_stage[k-1].g_mid.r_carry;
            assign w_res   = {w_sum[CHUNK-1:0], g_stage[k-1].g_mid.r_res};
`ifdef ADDSUB_SAT_EN
            assign w_sat   = g_stage[k-1].g_mid.r_sat;
`endif
        end

        assign w_sum = {1'b0, w_a_hi[CHUNK-1:0]}
                     + {1'b0, w_bp_hi[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, w_cin};

        if (k < STAGES - 1) begin : g_mid
            logic                  r_vld;
            logic                  r_carry;
            logic [TAG_W-1:0]      r_tag;
            logic [LO_W+CHUNK-1:0] r_res;
            logic [HI_W-CHUNK-1:0] r_a_hi;
            logic [HI_W-CHUNK-1:0] r_bp_hi;
`ifdef ADDSUB_SAT_EN
            logic                  r_sat;
`endif

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_vld   <= 1'b0;
                    r_carry <= 1'b0;
                    r_tag   <= '0;
                    r_res   <= '0;
                    r_a_hi  <= '0;
                    r_bp_hi <= '0;
`ifdef ADDSUB_SAT_EN
                    r_sat   <= 1'b0;
`endif
                end else if (w_adv) begin
                    r_vld   <= w_vld;
                    r_carry <= w_sum[CHUNK];
                    r_tag   <= w_tag;
                    r_res   <= w_res;
                    r_a_hi  <= w_a_hi[HI_W-1:CHUNK];
                    r_bp_hi <= w_bp_hi[HI_W-1:CHUNK];
`ifdef ADDSUB_SAT_EN
                    r_sat   <= w_sat;
`endif
                end
            end
        end else begin : g_last
            logic             w_ovf;
            logic             w_neq;
            logic             w_lt;
            logic [WIDTH-1:0] w_out;

            // Top slice still holds the operand MSBs needed for overflow.
            assign w_ovf = (w_a_hi[CHUNK-1] == w_bp_hi[CHUNK-1])
                        && (w_res[WIDTH-1] != w_a_hi[CHUNK-1]);
            assign w_neq = (|w_res) || w_ovf;
            assign w_lt  = w_res[WIDTH-1] ^ w_ovf;

`ifdef ADDSUB_SAT_EN
            // Flags keep describing the wrapped result; only the data clamps.
            assign w_out = (w_sat && w_ovf) ? (w_a_hi[CHUNK-1] ? c_sat_min : c_sat_max)
                                            : w_res;
`else
            assign w_out = w_res;
`endif

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_out_vld <= 1'b0;
                    r_out     <= '0;
                    r_out_tag <= '0;
                    r_cout    <= 1'b0;
                    r_ovf     <= 1'b0;
                    r_neq     <= 1'b0;
                    r_lt      <= 1'b0;
                end else if (w_adv) begin
                    r_out_vld <= w_vld;
                    if (w_vld) begin
                        r_out     <= w_out;
                        r_out_tag <= w_tag;
                        r_cout    <= w_sum[CHUNK];
                        r_ovf     <= w_ovf;
                        r_neq     <= w_neq;
                        r_lt      <= w_lt;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_addsub
//  Brief    : Scoreboard bench for pipe_addsub (WIDTH=32, CHUNK=8, 4 stages);
//             directed vectors, stall, and mid-flight reset scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_addsub;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int TAG_W = 4;
    localparam int LAT   = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipe_addsub_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus_if ();

    pipe_addsub #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .TAG_W (TAG_W)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        cout;
        logic        ovf;
        logic        neq;
        logic        lt;
    } exp_t;

    typedef struct {
        exp_t e;
        int   acc;
        bit   lat_chk;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    // Monitor: pops one expectation per completed output handshake.
    always @(negedge clk) begin
        exp_t act;
        sb_t  s;
        if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
            act = {bus_if.out, bus_if.out_tag, bus_if.cout, bus_if.overflow_out,
                   bus_if.neq_out, bus_if.lt_out};
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got out 0x%0h tag %0h, required no output (cycle %0d)",
                         bus_if.out, bus_if.out_tag, cyc);
            end else begin
                s = sb_q.pop_front();
                check($sformatf("result_tag%0h {out,tag,cout,ovf,neq,lt}", s.e.tag),
                      64'(act), 64'(s.e));
                if (s.lat_chk)
                    check($sformatf("latency_tag%0h", s.e.tag), 64'(cyc - s.acc), 64'(LAT));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic s, input exp_t e, input bit lat_chk);
        int  n;
        bit  acc;
        sb_t t;
        bus_if.in_valid = 1'b1;
        bus_if.in1      = a;
        bus_if.in2      = b;
        bus_if.addsub   = op;
        bus_if.in_tag   = e.tag;
`ifdef ADDSUB_SAT_EN
        bus_if.sat      = s;
`endif
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (bus_if.in_ready) acc = 1'b1;
            n++;
        end
        if (acc) begin
            t.e       = e;
            t.acc     = cyc;
            t.lat_chk = lat_chk;
            sb_q.push_back(t);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout tag %0h sat %0b: in_ready stayed 0, required 1 within 50 cycles",
                     e.tag, s);
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic vec(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic s, input logic [3:0] tag, input logic [31:0] res,
                       input logic co, input logic ov, input logic ne, input logic lt);
        exp_t e;
        e = {res, tag, co, ov, ne, lt};
        issue(a, b, op, s, e, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in1       = '0;
        bus_if.in2       = '0;
        bus_if.addsub    = 1'b0;
        bus_if.in_tag    = '0;
        bus_if.out_ready = 1'b1;
`ifdef ADDSUB_SAT_EN
        bus_if.sat       = 1'b0;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state {valid,out,tag,flags}",
              64'({bus_if.out_valid, bus_if.out, bus_if.out_tag, bus_if.cout,
                   bus_if.overflow_out, bus_if.neq_out, bus_if.lt_out}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", 64'(bus_if.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // a, b, sub, sat, tag, result, cout, ovf, neq, lt
        vec(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 4'h2, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
        vec(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'h3, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
`else
        vec(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'h3, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
        vec(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 4'h4, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h5, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        vec(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h6, 32'h0100_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        vec(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 4'h7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1);
        vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h8, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
        vec(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 4'h9, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        vec(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 4'hA, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
`else
        vec(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 4'h9, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        vec(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 4'hA, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
`endif
        vec(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 4'hB, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();

        // Back-to-back stream of 8 (i + i) with a 3-cycle output stall.
        fork
            begin
                exp_t e;
                for (int i = 0; i < 8; i++) begin
                    e = {32'(2 * i), 4'(i), 1'b0, 1'b0, (i != 0), 1'b0};
                    issue(32'(i), 32'(i), 1'b0, 1'b0, e, 1'b0);
                end
            end
            begin
                int n;
                n = 0;
                while (!bus_if.out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("stream_output_seen", 64'(bus_if.out_valid), 64'd1);
                @(posedge clk);
                #1;
                bus_if.out_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    check($sformatf("in_ready_during_hold%0d", h), 64'(bus_if.in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                bus_if.out_ready = 1'b1;
            end
        join
        drain();

        // Three ops in flight, stalled at the output, then reset mid-cycle.
        bus_if.out_ready = 1'b0;
        vec(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 4'hC, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0);
        vec(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 4'hD, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 1'b0);
        vec(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 4'hE, 32'h0000_0006, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("out_valid_before_reset", 64'(bus_if.out_valid), 64'd1);
        #2;
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        check("reset_mid_flight {valid,out,tag,flags}",
              64'({bus_if.out_valid, bus_if.out, bus_if.out_tag, bus_if.cout,
                   bus_if.overflow_out, bus_if.neq_out, bus_if.lt_out}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
        rst_n            = 1'b1;
        @(negedge clk);
        check("in_ready_after_midflight_reset", 64'(bus_if.in_ready), 64'd1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        vec(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 4'hF, 32'h0000_0030, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
